flag_file: RTL and testbench

//  Parametrised condition-flag register with per-bit write mask, save/restore

---
 rtl/flag_file_if.sv | 35 +++
 rtl/flag_file.sv | 104 ++++++++++
 tb/tb_flag_file.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/flag_file_if.sv
// Bus between the flag file and its clients (ALU flag source / branch unit).
// Params : FLAG_W flag width, STACK_DEPTH save/restore stack entries.
// master : ALU/branch side; drives write, stack and condition requests,
//          observes flags, condition result and stack status.
// slave  : flag file; the reverse direction of every signal.
interface flag_file_if #(
  parameter int unsigned FLAG_W      = 3,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic              flag_wr_en;
  logic [FLAG_W-1:0] flag_wr_mask;
  logic [FLAG_W-1:0] flag_in;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [2:0]        cond;
  logic [FLAG_W-1:0] flag_out;
  logic              cond_true;
  logic [CNT_W-1:0]  stack_cnt;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output flag_wr_en, flag_wr_mask, flag_in, push, pop, err_clr, cond,
    input  flag_out, cond_true, stack_cnt, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  flag_wr_en, flag_wr_mask, flag_in, push, pop, err_clr, cond,
    output flag_out, cond_true, stack_cnt, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flag_file.sv
// Condition-flag register with masked writes, a LIFO save/restore stack and
// branch-condition evaluation. State updates on the falling clock edge so the
// branch unit sees fresh flags on the following rising edge.
// Ports: clk   - clock (state changes on negedge)
//        rst   - asynchronous reset, active-high
//        bus   - flag_file_if.slave: write/mask/data, push/pop/err_clr, cond
//                in; flag_out, cond_true (combinational), stack status out.
module flag_file #(
  parameter int unsigned FLAG_W      = 3,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned FWD         = 1
) (
  input  logic         clk,
  input  logic         rst,
  flag_file_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [FLAG_W-1:0] stack_d [STACK_DEPTH];

  logic              full, empty;
  logic              push_ok, pop_ok, err_evt;
  logic [FLAG_W-1:0] merged, eff;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic              n_f, z_f, v_f;

  // Stack status and request qualification
  always_comb begin
    full     = (cnt_q == CNT_W'(STACK_DEPTH));
    empty    = (cnt_q == '0);
    push_ok  = bus.push & ~bus.pop & ~full;
    pop_ok   = bus.pop & ~bus.push & ~empty;
    err_evt  = (bus.push & bus.pop) | (bus.push & ~bus.pop & full) |
               (bus.pop & ~bus.push & empty);
    push_idx = IDX_W'(cnt_q);
    pop_idx  = IDX_W'(cnt_q - CNT_W'(1));
    merged   = (bus.flag_wr_mask & bus.flag_in) | (~bus.flag_wr_mask & flag_q);
  end

  // Next-state: a successful pop overrides any same-cycle write
  always_comb begin
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (bus.flag_wr_en) flag_d = merged;
    if (push_ok) begin
      stack_d[push_idx] = flag_q;  // pre-write value is saved
      cnt_d             = cnt_q + CNT_W'(1);
    end
    if (pop_ok) begin
      flag_d = stack_q[pop_idx];
      cnt_d  = cnt_q - CNT_W'(1);
    end
    if (err_evt)          err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  // State registers, falling edge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  // Branch condition on effective flags; forwarding keys off raw pop
  always_comb begin
    eff = ((FWD != 0) && bus.flag_wr_en && !bus.pop) ? merged : flag_q;
    n_f = eff[2];
    z_f = eff[1];
    v_f = eff[0];
    bus.cond_true = 1'b0;
    unique case (bus.cond)
      3'b000: bus.cond_true = ~z_f;
      3'b001: bus.cond_true = z_f;
      3'b010: bus.cond_true = ~z_f & ~n_f;
      3'b011: bus.cond_true = n_f;
      3'b100: bus.cond_true = z_f | ~n_f;
      3'b101: bus.cond_true = n_f | z_f;
      3'b110: bus.cond_true = v_f;
      3'b111: bus.cond_true = 1'b1;
      default: bus.cond_true = 1'b0;
    endcase
  end

  assign bus.flag_out    = flag_q;
  assign bus.stack_cnt   = cnt_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_flag_file.sv
// Self-checking bench for flag_file: a behavioural model computes expected
// state per cycle, pushes it to a scoreboard queue, and the entry is popped
// and compared after the updating falling edge.
module tb_flag_file;
  localparam int unsigned FW = 3;
  localparam int unsigned D  = 4;

  typedef struct {
    logic [2:0] flags;
    int         cnt;
    bit         full;
    bit         empty;
    bit         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exp_t       exp_q[$];
  logic [2:0] m_flags = '0;
  logic [2:0] m_stack[$];
  bit         m_err = 1'b0;

  flag_file_if #(.FLAG_W(FW), .STACK_DEPTH(D)) bus ();

  flag_file #(.FLAG_W(FW), .STACK_DEPTH(D), .FWD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_model(input logic [2:0] f, input logic [2:0] c);
    bit n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.flag_wr_en = 0; bus.flag_wr_mask = '0; bus.flag_in = '0;
    bus.push = 0; bus.pop = 0; bus.err_clr = 0; bus.cond = 3'd7;
  endtask

  // One cycle: drive after rising edge, check cond_true, check state after negedge
  task automatic step(input bit wr, input logic [2:0] mask, input logic [2:0] din,
                      input bit psh, input bit pp, input bit clr, input logic [2:0] cnd);
    logic [2:0] merged, eff, nxt;
    bit push_ok, pop_ok, evt, exp_c;
    exp_t e, got;
    @(posedge clk); #1;
    bus.flag_wr_en = wr; bus.flag_wr_mask = mask; bus.flag_in = din;
    bus.push = psh; bus.pop = pp; bus.err_clr = clr; bus.cond = cnd;

    merged  = (mask & din) | (~mask & m_flags);
    eff     = (wr && !pp) ? merged : m_flags;
    exp_c   = cond_model(eff, cnd);
    push_ok = psh && !pp && (m_stack.size() < D);
    pop_ok  = pp && !psh && (m_stack.size() > 0);
    evt     = (psh && pp) || (psh && !pp && m_stack.size() == D) ||
              (pp && !psh && m_stack.size() == 0);
    nxt = m_flags;
    if (wr) nxt = merged;
    if (push_ok) m_stack.push_back(m_flags);
    if (pop_ok)  nxt = m_stack.pop_back();
    m_flags = nxt;
    if (evt) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    e.flags = m_flags; e.cnt = m_stack.size();
    e.full = (m_stack.size() == D); e.empty = (m_stack.size() == 0); e.err = m_err;
    exp_q.push_back(e);

    #1 chk("cond_true", 32'(bus.cond_true), 32'(exp_c));
    @(negedge clk); #1;
    chk("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("flag_out",    32'(bus.flag_out),    32'(got.flags));
      chk("stack_cnt",   32'(bus.stack_cnt),   32'(got.cnt));
      chk("stack_full",  32'(bus.stack_full),  32'(got.full));
      chk("stack_empty", 32'(bus.stack_empty), 32'(got.empty));
      chk("stack_err",   32'(bus.stack_err),   32'(got.err));
    end
    idle_inputs();
  endtask

  // Asynchronous reset: outputs must clear without any clock edge
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_flag_out",    32'(bus.flag_out),    32'd0);
    chk("rst_stack_cnt",   32'(bus.stack_cnt),   32'd0);
    chk("rst_stack_empty", 32'(bus.stack_empty), 32'd1);
    chk("rst_stack_full",  32'(bus.stack_full),  32'd0);
    chk("rst_stack_err",   32'(bus.stack_err),   32'd0);
    m_flags = '0; m_stack.delete(); m_err = 1'b0; exp_q.delete();
    #2 rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1;
    chk("init_flag_out",    32'(bus.flag_out),    32'd0);
    chk("init_stack_empty", 32'(bus.stack_empty), 32'd1);
    #2 rst = 1'b0;

    // Same-cycle forwarding: OV sees V written this cycle
    step(1, 3'b111, 3'b001, 0, 0, 0, 3'b110);
    // Full write, EQ forwarded then registered
    step(1, 3'b111, 3'b010, 0, 0, 0, 3'b001);
    step(0, 3'b000, 3'b000, 0, 0, 0, 3'b001);
    // Mask=0 leaves flags unchanged
    step(1, 3'b000, 3'b111, 0, 0, 0, 3'b000);
    // Partial mask merge: 101 with mask 010 in 111 -> 111
    step(1, 3'b111, 3'b101, 0, 0, 0, 3'b011);
    step(1, 3'b010, 3'b111, 0, 0, 0, 3'b101);
    // Push saves pre-write value, pop restores and discards same-cycle write
    step(1, 3'b111, 3'b100, 0, 0, 0, 3'b010);
    step(0, 3'b000, 3'b000, 1, 0, 0, 3'b100);
    step(1, 3'b111, 3'b010, 0, 0, 0, 3'b000);
    step(1, 3'b111, 3'b001, 0, 1, 0, 3'b011);
    // Push with write in the same cycle
    step(1, 3'b111, 3'b011, 1, 0, 0, 3'b110);
    step(0, 3'b000, 3'b000, 0, 1, 0, 3'b111);
    // Overflow: five pushes into a 4-deep stack
    for (int i = 0; i < 5; i++) step(1, 3'b111, 3'(i), 1, 0, 0, 3'(i));
    // err_clr clears sticky error; then collision with clear -> set wins
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b000);
    step(1, 3'b001, 3'b001, 1, 1, 1, 3'b110);
    step(0, 3'b000, 3'b000, 0, 0, 1, 3'b000);
    // Drain and underflow
    for (int i = 0; i < 5; i++) step(0, 3'b000, 3'b000, 0, 1, 0, 3'(i + 2));
    step(1, 3'b110, 3'b110, 0, 1, 0, 3'b100);

    // Mid-run reset with stack occupied
    step(0, 3'b000, 3'b000, 1, 0, 0, 3'b111);
    step(1, 3'b111, 3'b111, 1, 0, 1, 3'b111);
    do_reset();
    step(0, 3'b000, 3'b000, 0, 0, 0, 3'b000);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the flow above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
